pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage pipeline. Detects load-use and branch hazards, generates operand-forwarding selects for the ID/EX register, and drives the stall, flush and enable controls of the PC, IF/ID, ID/EX and EX/MEM registers. Also sequences multi-cycle multiply/divide (MDU) ops occupying EX, and keeps saturating stall/flush event counters for performance debug.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipeline_hazard_ctrl_fwd_sel.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl_pkg
// Brief   : Shared state encoding and forwarding-select constants
// Rev     : 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MDU_BUSY = 1'b1
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_LD  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl_fwd_sel
// Brief   : Forwarding select and load-use detect for one source operand
// Rev     : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl_fwd_sel
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic       use_src,
   input  logic [4:0] src,
   input  logic       ex_wreg,
   input  logic       ex_m2reg,
   input  logic [4:0] ex_rd,
   input  logic       mem_wreg,
   input  logic       mem_m2reg,
   input  logic [4:0] mem_rd,
   output logic [1:0] sel,
   output logic       load_use
);

   logic w_live;
   logic w_ex_hit;
   logic w_mem_hit;

   // r0 is hard-wired zero, so it never needs a bypass or a stall
   assign w_live    = use_src && (src != 5'd0);
   assign w_ex_hit  = w_live && ex_wreg && (ex_rd == src);
   assign w_mem_hit = w_live && mem_wreg && (mem_rd == src);

   assign load_use  = w_ex_hit && ex_m2reg;

   always_comb begin
      sel = FWD_RF;
      if (w_ex_hit && !ex_m2reg) begin
         sel = FWD_EX;
      end else if (w_mem_hit) begin
         sel = mem_m2reg ? FWD_LD : FWD_MEM;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Hazard detection, forwarding, MDU sequencing and event counters
// Rev     : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MDU_LAT = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_mdu,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [4:0]       ex_rd,
   input  logic             mem_wreg,
   input  logic             mem_m2reg,
   input  logic [4:0]       mem_rd,
   input  logic             br_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             ifid_flush,
   output logic             stall,
   output logic             condep,
   output logic             exmem_bubble,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned    BW        = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
   localparam logic [BW-1:0]  BUSY_INIT = BW'(MDU_LAT - 1);
   localparam bit             MDU_MULTI = (MDU_LAT > 1);

   state_t          r_state;
   logic [BW-1:0]   r_busy_cnt;
   logic [1:0]      w_sel_a;
   logic [1:0]      w_sel_b;
   logic            w_lu_a;
   logic            w_lu_b;
   logic            w_load_use;
   logic            w_run;
   logic            w_flush_evt;
   logic            w_mdu_start;

   pipeline_hazard_ctrl_fwd_sel u_fwd_a (
      .use_src   (id_use_rs),
      .src       (id_rs),
      .ex_wreg   (ex_wreg),
      .ex_m2reg  (ex_m2reg),
      .ex_rd     (ex_rd),
      .mem_wreg  (mem_wreg),
      .mem_m2reg (mem_m2reg),
      .mem_rd    (mem_rd),
      .sel       (w_sel_a),
      .load_use  (w_lu_a)
   );

   pipeline_hazard_ctrl_fwd_sel u_fwd_b (
      .use_src   (id_use_rt),
      .src       (id_rt),
      .ex_wreg   (ex_wreg),
      .ex_m2reg  (ex_m2reg),
      .ex_rd     (ex_rd),
      .mem_wreg  (mem_wreg),
      .mem_m2reg (mem_m2reg),
      .mem_rd    (mem_rd),
      .sel       (w_sel_b),
      .load_use  (w_lu_b)
   );

   assign w_load_use  = w_lu_a || w_lu_b;
   assign w_run       = (r_state == ST_RUN);
   // A taken branch squashes the ID instruction, so its hazards and MDU request vanish
   assign w_flush_evt = w_run && br_taken && !Clr;
   assign w_mdu_start = MDU_MULTI && w_run && id_mdu && !br_taken && !w_load_use;

   always_comb begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      ifid_flush   = 1'b0;
      stall        = 1'b0;
      condep       = 1'b0;
      exmem_bubble = 1'b0;
      fwda         = FWD_RF;
      fwdb         = FWD_RF;
      if (!Clr) begin
         fwda = w_sel_a;
         fwdb = w_sel_b;
         if (!w_run) begin
            exmem_bubble = 1'b1;
         end else if (br_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            ifid_flush = 1'b1;
            condep     = 1'b1;
         end else if (w_load_use) begin
            idex_en = 1'b1;
            stall   = 1'b1;
         end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         r_state    <= ST_RUN;
         r_busy_cnt <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_mdu_start) begin
                  r_state    <= ST_MDU_BUSY;
                  r_busy_cnt <= BUSY_INIT;
               end
            end
            ST_MDU_BUSY: begin
               r_busy_cnt <= r_busy_cnt - BW'(1);
               if (r_busy_cnt == BW'(1)) begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (w_flush_evt && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed and randomized checks against a behavioural model
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

   localparam int MDU_LAT = 4;

   logic       Clk = 1'b0;
   logic       Clr;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       id_use_rs, id_use_rt, id_mdu;
   logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, br_taken;

   logic        pc_en, ifid_en, idex_en, ifid_flush, stall, condep, exmem_bubble;
   logic [1:0]  fwda, fwdb;
   logic [15:0] stall_cnt, flush_cnt;

   logic        pc_en_s, ifid_en_s, idex_en_s, ifid_flush_s, stall_s, condep_s, exmem_bubble_s;
   logic [1:0]  fwda_s, fwdb_s;
   logic [3:0]  stall_cnt_s, flush_cnt_s;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model state
   int     busy_left = 0;
   longint m_scnt = 0;
   longint m_fcnt = 0;
   logic   e_pc_en, e_ifid_en, e_idex_en, e_flush, e_stall, e_condep, e_bubble, e_lu;
   logic [1:0] e_fwda, e_fwdb;

   always #5 Clk = ~Clk;

   pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(16)) dut (
      .Clk(Clk), .Clr(Clr), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_mdu(id_mdu),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rd(mem_rd),
      .br_taken(br_taken), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .ifid_flush(ifid_flush), .stall(stall), .condep(condep),
      .exmem_bubble(exmem_bubble), .fwda(fwda), .fwdb(fwdb),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(4)) dut_s (
      .Clk(Clk), .Clr(Clr), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_mdu(id_mdu),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rd(mem_rd),
      .br_taken(br_taken), .pc_en(pc_en_s), .ifid_en(ifid_en_s), .idex_en(idex_en_s),
      .ifid_flush(ifid_flush_s), .stall(stall_s), .condep(condep_s),
      .exmem_bubble(exmem_bubble_s), .fwda(fwda_s), .fwdb(fwdb_s),
      .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic u, input logic [4:0] r);
      if (!u || r == 5'd0) return 2'd0;
      if (ex_wreg && !ex_m2reg && ex_rd == r) return 2'd1;
      if (mem_wreg && mem_rd == r) return mem_m2reg ? 2'd3 : 2'd2;
      return 2'd0;
   endfunction

   function automatic logic m_hz(input logic u, input logic [4:0] r);
      return u && r != 5'd0 && ex_wreg && ex_m2reg && ex_rd == r;
   endfunction

   function automatic longint sat(input longint v, input int w);
      longint mx;
      mx = (64'sd1 <<< w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // Evaluate the model on the current inputs and compare every output
   task automatic step_cmp();
      @(negedge Clk);
      e_lu = m_hz(id_use_rs, id_rs) || m_hz(id_use_rt, id_rt);
      {e_pc_en, e_ifid_en, e_idex_en, e_flush, e_stall, e_condep, e_bubble} = '0;
      e_fwda = 2'd0;
      e_fwdb = 2'd0;
      if (Clr) begin
         busy_left = 0;
         m_scnt = 0;
         m_fcnt = 0;
      end else begin
         e_fwda = m_fwd(id_use_rs, id_rs);
         e_fwdb = m_fwd(id_use_rt, id_rt);
         if (busy_left > 0) e_bubble = 1'b1;
         else if (br_taken) {e_pc_en, e_ifid_en, e_idex_en, e_flush, e_condep} = '1;
         else if (e_lu) {e_idex_en, e_stall} = '1;
         else {e_pc_en, e_ifid_en, e_idex_en} = '1;
      end
      chk("pc_en", pc_en, e_pc_en);
      chk("ifid_en", ifid_en, e_ifid_en);
      chk("idex_en", idex_en, e_idex_en);
      chk("ifid_flush", ifid_flush, e_flush);
      chk("stall", stall, e_stall);
      chk("condep", condep, e_condep);
      chk("exmem_bubble", exmem_bubble, e_bubble);
      chk("fwda", fwda, e_fwda);
      chk("fwdb", fwdb, e_fwdb);
      chk("stall_cnt", stall_cnt, sat(m_scnt, 16));
      chk("flush_cnt", flush_cnt, sat(m_fcnt, 16));
      chk("pc_en_s", pc_en_s, e_pc_en);
      chk("stall_cnt_s", stall_cnt_s, sat(m_scnt, 4));
      chk("flush_cnt_s", flush_cnt_s, sat(m_fcnt, 4));
   endtask

   task automatic step_adv();
      @(posedge Clk);
      if (!Clr) begin
         if (!e_pc_en) m_scnt++;
         if (busy_left == 0 && br_taken) m_fcnt++;
         if (busy_left > 0) busy_left--;
         else if (!br_taken && !e_lu && id_mdu && MDU_LAT > 1) busy_left = MDU_LAT - 1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      {id_rs, id_rt, ex_rd, mem_rd} = '0;
      {id_use_rs, id_use_rt, id_mdu, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, br_taken} = '0;
   endtask

   task automatic do_reset();
      Clr = 1'b1;
      idle_inputs();
      step_cmp();
      chk("rst_pc_en", pc_en, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      step_adv();
      step_cmp();
      step_adv();
      Clr = 1'b0;
   endtask

   initial begin
      Clr = 1'b1;
      idle_inputs();
      do_reset();

      // load-use on rs then forwarding from MEM load data
      id_rs = 5'd5; id_use_rs = 1'b1; ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd5;
      step_cmp();
      chk("lu_pc_en", pc_en, 0);
      chk("lu_ifid_en", ifid_en, 0);
      chk("lu_stall", stall, 1);
      step_adv();
      ex_wreg = 1'b0; ex_m2reg = 1'b0; mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rd = 5'd5;
      step_cmp();
      chk("lu_next_fwda", fwda, 3);
      chk("lu_next_stall", stall, 0);
      chk("lu_stall_cnt", stall_cnt, 1);
      step_adv();

      // EX result beats MEM for rt; r0 never stalls nor forwards
      idle_inputs();
      id_rt = 5'd3; id_use_rt = 1'b1; ex_wreg = 1'b1; ex_rd = 5'd3; mem_wreg = 1'b1; mem_rd = 5'd3;
      step_cmp();
      chk("ex_prio_fwdb", fwdb, 1);
      step_adv();
      idle_inputs();
      id_use_rs = 1'b1; ex_wreg = 1'b1; ex_m2reg = 1'b1;
      step_cmp();
      chk("r0_fwda", fwda, 0);
      chk("r0_stall", stall, 0);
      step_adv();

      // branch taken together with a load-use hazard and an MDU request
      do_reset();
      id_rs = 5'd7; id_use_rs = 1'b1; ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd7;
      br_taken = 1'b1; id_mdu = 1'b1;
      step_cmp();
      chk("br_flush", ifid_flush, 1);
      chk("br_condep", condep, 1);
      chk("br_stall", stall, 0);
      chk("br_pc_en", pc_en, 1);
      step_adv();
      idle_inputs();
      step_cmp();
      chk("br_flush_cnt", flush_cnt, 1);
      chk("br_stall_cnt", stall_cnt, 0);
      chk("br_no_mdu", exmem_bubble, 0);
      step_adv();

      // MDU op: three busy cycles, then back to RUN
      do_reset();
      id_mdu = 1'b1;
      step_cmp();
      step_adv();
      id_mdu = 1'b0; br_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step_cmp();
         chk("mdu_busy_pc_en", pc_en, 0);
         chk("mdu_busy_bubble", exmem_bubble, 1);
         chk("mdu_busy_flush", ifid_flush, 0);
         step_adv();
      end
      br_taken = 1'b0;
      step_cmp();
      chk("mdu_done_pc_en", pc_en, 1);
      chk("mdu_stall_cnt", stall_cnt, 3);
      chk("mdu_flush_cnt", flush_cnt, 0);
      step_adv();

      // reset in the second busy cycle aborts the MDU op
      do_reset();
      id_mdu = 1'b1;
      step_cmp();
      step_adv();
      id_mdu = 1'b0;
      step_cmp();
      step_adv();
      Clr = 1'b1;
      step_cmp();
      chk("abort_bubble", exmem_bubble, 0);
      chk("abort_pc_en", pc_en, 0);
      chk("abort_stall_cnt", stall_cnt, 0);
      step_adv();
      Clr = 1'b0;
      step_cmp();
      chk("abort_run_pc_en", pc_en, 1);
      chk("abort_run_cnt", stall_cnt, 0);
      step_adv();

      // 20 consecutive load-use stalls saturate a 4-bit counter
      do_reset();
      id_rt = 5'd9; id_use_rt = 1'b1; ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd9;
      for (int i = 0; i < 20; i++) begin
         step_cmp();
         step_adv();
      end
      idle_inputs();
      step_cmp();
      chk("sat_stall_cnt_s", stall_cnt_s, 15);
      chk("sat_stall_cnt", stall_cnt, 20);
      step_adv();

      // randomized traffic with small register indices to provoke matches
      for (int i = 0; i < 4000; i++) begin
         Clr       = ($urandom_range(0, 249) == 0);
         id_rs     = 5'($urandom_range(0, 3));
         id_rt     = 5'($urandom_range(0, 3));
         ex_rd     = 5'($urandom_range(0, 3));
         mem_rd    = 5'($urandom_range(0, 3));
         id_use_rs = 1'($urandom_range(0, 1));
         id_use_rt = 1'($urandom_range(0, 1));
         ex_wreg   = 1'($urandom_range(0, 1));
         ex_m2reg  = 1'($urandom_range(0, 1));
         mem_wreg  = 1'($urandom_range(0, 1));
         mem_m2reg = 1'($urandom_range(0, 1));
         id_mdu    = ($urandom_range(0, 5) == 0);
         br_taken  = ($urandom_range(0, 7) == 0);
         step_cmp();
         step_adv();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
